// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a combinational hit path and
// a single-outstanding whole-line refill over a request/grant + beat handshake.
module icache #(
  parameter int WIDTH = 32,
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] instr_f,
  output logic             stall_icache,
  input  logic             inv,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int LSB   = OFF_W + 2;
  localparam int TAG_W = WIDTH - IDX_W - LSB;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t           state;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [WIDTH-1:0] data_arr [LINES][WORDS];
  logic             poison;
  logic [OFF_W-1:0] beat;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic             hit;
  logic             last_beat;
  logic             fill_we;
  logic             unused_pc;

  assign off       = pc_f[LSB-1:2];
  assign idx       = pc_f[LSB+IDX_W-1:LSB];
  assign tag       = pc_f[WIDTH-1:LSB+IDX_W];
  assign unused_pc = ^pc_f[1:0];

  // mem_addr doubles as the miss address register for the in-flight refill.
  assign miss_idx  = mem_addr[LSB+IDX_W-1:LSB];
  assign miss_tag  = mem_addr[WIDTH-1:LSB+IDX_W];

  assign hit          = (state == IDLE) && valid[idx] && (tag_arr[idx] == tag);
  assign stall_icache = ~hit;
  assign instr_f      = hit ? data_arr[idx][off] : '0;

  assign last_beat = (beat == OFF_W'(WORDS - 1));
  assign fill_we   = (state == FILL) && mem_rvalid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      poison   <= 1'b0;
      beat     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (inv) valid <= '0;
      case (state)
        IDLE: begin
          if (!hit && !inv) begin
            mem_addr <= {pc_f[WIDTH-1:LSB], {LSB{1'b0}}};
            mem_req  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (inv) poison <= 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            beat    <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (inv) poison <= 1'b1;
          if (mem_rvalid) begin
            beat <= beat + OFF_W'(1);
            if (last_beat) begin
              // An invalidate seen now or earlier in this refill keeps the line dead.
              if (!poison && !inv) valid[miss_idx] <= 1'b1;
              poison <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_arr[miss_idx][beat] <= mem_rdata;
      if (last_beat) tag_arr[miss_idx] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: a behavioural memory responder serves refills and
// expected refill addresses / instructions are queued at stimulus time.
module tb_icache;
  localparam int WIDTH = 32;
  localparam int LINES = 16;
  localparam int WORDS = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pc_f;
  logic [WIDTH-1:0] instr_f;
  logic             stall_icache;
  logic             inv;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;

  always #5 clk = ~clk;

  icache #(.WIDTH(WIDTH), .LINES(LINES), .WORDS(WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_f         (pc_f),
    .instr_f      (instr_f),
    .stall_icache (stall_icache),
    .inv          (inv),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  int checks = 0;
  int errors = 0;
  int gnt_delay = 0;
  int beat_gap = 0;
  logic [31:0] exp_req[$];
  logic [31:0] exp_instr[$];

  // Backing store: the line at 0x40 holds 0xA0..0xA3, everything else is address-tagged.
  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a[31:4] == 28'h4) return 32'hA0 + 32'(a[3:2]);
    return 32'h5000_0000 ^ a;
  endfunction

  task automatic wait_hit(output int n, output int reqs, output int addr_changes);
    logic [31:0] a0;
    a0 = '0;
    n = 0;
    reqs = 0;
    addr_changes = 0;
    while (stall_icache === 1'b1 && n < 200) begin
      if (mem_req === 1'b1) begin
        if (reqs > 0 && mem_addr !== a0) addr_changes++;
        a0 = mem_addr;
        reqs++;
      end
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; inv = 1'b0; pc_f = 32'h40;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (stall_icache !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b, expected 1", stall_icache); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b, expected 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h, expected 0", mem_addr); end
    checks++; if (instr_f !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h, expected 0", instr_f); end
  endtask

  task automatic test_cold_miss;
    int n, r, c;
    logic [31:0] e;
    exp_req.push_back(32'h40);
    exp_instr.push_back(32'hA0);
    @(negedge clk); rst = 1'b0; pc_f = 32'h40; #1;
    wait_hit(n, r, c);
    checks++; if (n !== 6) begin errors++; $display("FAIL cold_stall_cycles: got %0d, expected 6", n); end
    checks++; if (r !== 1) begin errors++; $display("FAIL cold_req_cycles: got %0d, expected 1", r); end
    e = exp_instr.pop_front();
    checks++; if (instr_f !== e) begin errors++; $display("FAIL cold_instr: got %h, expected %h", instr_f, e); end
    @(negedge clk); pc_f = 32'h4C; exp_instr.push_back(32'hA3); #1;
    e = exp_instr.pop_front();
    checks++; if (stall_icache !== 1'b0 || instr_f !== e) begin
      errors++; $display("FAIL cold_word3: stall=%b instr=%h, expected stall=0 instr=%h", stall_icache, instr_f, e);
    end
  endtask

  task automatic test_conflict;
    int n, r, c;
    logic [31:0] e;
    exp_req.push_back(32'h140);
    exp_instr.push_back(memval(32'h140));
    @(negedge clk); pc_f = 32'h140; #1;
    wait_hit(n, r, c);
    e = exp_instr.pop_front();
    checks++; if (n !== 6 || instr_f !== e) begin
      errors++; $display("FAIL conflict_fill: stalls=%0d instr=%h, expected 6 and %h", n, instr_f, e);
    end
    exp_req.push_back(32'h40);
    exp_instr.push_back(32'hA0);
    @(negedge clk); pc_f = 32'h40; #1;
    wait_hit(n, r, c);
    e = exp_instr.pop_front();
    checks++; if (n !== 6 || instr_f !== e) begin
      errors++; $display("FAIL conflict_evicted: stalls=%0d instr=%h, expected 6 and %h", n, instr_f, e);
    end
  endtask

  task automatic test_backpressure;
    int n, r, c;
    logic [31:0] e;
    gnt_delay = 3; beat_gap = 1;
    exp_req.push_back(32'h200);
    exp_instr.push_back(memval(32'h200));
    @(negedge clk); pc_f = 32'h200; #1;
    wait_hit(n, r, c);
    checks++; if (n !== 12) begin errors++; $display("FAIL bp_stall_cycles: got %0d, expected 12", n); end
    checks++; if (r !== 4) begin errors++; $display("FAIL bp_req_cycles: got %0d, expected 4", r); end
    checks++; if (c !== 0) begin errors++; $display("FAIL bp_addr_stable: got %0d changes, expected 0", c); end
    e = exp_instr.pop_front();
    checks++; if (instr_f !== e) begin errors++; $display("FAIL bp_word0: got %h, expected %h", instr_f, e); end
    for (int w = 1; w < WORDS; w++) begin
      @(negedge clk); pc_f = 32'h200 + 32'(4 * w); exp_instr.push_back(memval(pc_f)); #1;
      e = exp_instr.pop_front();
      checks++; if (stall_icache !== 1'b0 || instr_f !== e) begin
        errors++; $display("FAIL bp_word%0d: stall=%b instr=%h, expected stall=0 instr=%h", w, stall_icache, instr_f, e);
      end
    end
    gnt_delay = 0; beat_gap = 0;
  endtask

  task automatic test_redirect;
    int n, r, c;
    logic [31:0] e;
    exp_req.push_back(32'h80);
    @(negedge clk); pc_f = 32'h80; #1;
    repeat (3) @(negedge clk);
    pc_f = 32'h40; exp_instr.push_back(32'hA0); #1;
    wait_hit(n, r, c);
    e = exp_instr.pop_front();
    checks++; if (n !== 3 || instr_f !== e) begin
      errors++; $display("FAIL redirect_hit: stalls=%0d instr=%h, expected 3 and %h", n, instr_f, e);
    end
    @(negedge clk); pc_f = 32'h80; exp_instr.push_back(memval(32'h80)); #1;
    e = exp_instr.pop_front();
    checks++; if (stall_icache !== 1'b0 || instr_f !== e) begin
      errors++; $display("FAIL redirect_line_kept: stall=%b instr=%h, expected stall=0 instr=%h", stall_icache, instr_f, e);
    end
  endtask

  task automatic test_invalidate;
    int n, r, c;
    logic [31:0] e;
    // inv in IDLE on a missing pc: no refill for 0x300 may start.
    @(negedge clk); pc_f = 32'h300; inv = 1'b1; #1;
    exp_req.push_back(32'h40);
    exp_instr.push_back(32'hA0);
    @(negedge clk); inv = 1'b0; pc_f = 32'h40; #1;
    wait_hit(n, r, c);
    e = exp_instr.pop_front();
    checks++; if (n !== 6 || instr_f !== e) begin
      errors++; $display("FAIL inv_idle: stalls=%0d instr=%h, expected 6 and %h", n, instr_f, e);
    end
    // inv mid-FILL: the refill completes poisoned and 0x80 is fetched again.
    exp_req.push_back(32'h80);
    exp_req.push_back(32'h80);
    exp_instr.push_back(memval(32'h80));
    @(negedge clk); pc_f = 32'h80; #1;
    repeat (3) @(negedge clk);
    inv = 1'b1;
    @(negedge clk); inv = 1'b0; #1;
    wait_hit(n, r, c);
    e = exp_instr.pop_front();
    checks++; if (4 + n !== 12 || instr_f !== e) begin
      errors++; $display("FAIL inv_fill: stalls=%0d instr=%h, expected 12 and %h", 4 + n, instr_f, e);
    end
    // inv on the final-beat edge.
    exp_req.push_back(32'h40);
    exp_req.push_back(32'h40);
    exp_instr.push_back(32'hA0);
    @(negedge clk); pc_f = 32'h40; #1;
    repeat (5) @(negedge clk);
    inv = 1'b1;
    @(negedge clk); inv = 1'b0; #1;
    wait_hit(n, r, c);
    e = exp_instr.pop_front();
    checks++; if (6 + n !== 12 || instr_f !== e) begin
      errors++; $display("FAIL inv_last_beat: stalls=%0d instr=%h, expected 12 and %h", 6 + n, instr_f, e);
    end
  endtask

  task automatic test_reset_mid_fill;
    int n, r, c;
    logic [31:0] e;
    beat_gap = 1;
    exp_req.push_back(32'h80);
    @(negedge clk); pc_f = 32'h80; #1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; pc_f = 32'h40;
    exp_req.push_back(32'h40);
    exp_instr.push_back(32'hA0);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstfill_mem_req: got %b, expected 0", mem_req); end
    checks++; if (stall_icache !== 1'b1) begin errors++; $display("FAIL rstfill_lookup: stall=%b, expected 1", stall_icache); end
    wait_hit(n, r, c);
    checks++; if (n !== 12) begin errors++; $display("FAIL rstfill_stall_cycles: got %0d, expected 12", n); end
    e = exp_instr.pop_front();
    checks++; if (instr_f !== e) begin errors++; $display("FAIL rstfill_word0: got %h, expected %h", instr_f, e); end
    for (int w = 1; w < WORDS; w++) begin
      @(negedge clk); pc_f = 32'h40 + 32'(4 * w); exp_instr.push_back(memval(pc_f)); #1;
      e = exp_instr.pop_front();
      checks++; if (stall_icache !== 1'b0 || instr_f !== e) begin
        errors++; $display("FAIL rstfill_word%0d: stall=%b instr=%h, expected stall=0 instr=%h", w, stall_icache, instr_f, e);
      end
    end
    beat_gap = 0;
  endtask

  initial begin
    rst = 1'b1; inv = 1'b0; pc_f = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    fork
      begin : responder
        logic [31:0] base;
        forever begin
          @(negedge clk);
          if (mem_req === 1'b1) begin
            base = mem_addr;
            repeat (gnt_delay) @(negedge clk);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            for (int w = 0; w < WORDS; w++) begin
              mem_rvalid = 1'b1;
              mem_rdata = memval(base + 32'(4 * w));
              @(negedge clk);
              mem_rvalid = 1'b0;
              if (w < WORDS - 1) repeat (beat_gap) @(negedge clk);
            end
          end
        end
      end
      begin : req_monitor
        logic [31:0] e;
        forever begin
          @(negedge clk); #2;
          if (rst === 1'b0 && mem_req === 1'b1 && mem_gnt === 1'b1) begin
            checks++;
            if (exp_req.size() == 0) begin
              errors++; $display("FAIL req_unexpected: mem_addr=%h, expected no request", mem_addr);
            end else begin
              e = exp_req.pop_front();
              if (mem_addr !== e) begin
                errors++; $display("FAIL req_addr: got %h, expected %h", mem_addr, e);
              end
            end
          end
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
      end
    join_none

    test_reset();
    test_cold_miss();
    test_conflict();
    test_backpressure();
    test_redirect();
    test_invalidate();
    test_reset_mid_fill();

    repeat (3) @(negedge clk);
    checks++; if (exp_req.size() != 0) begin errors++; $display("FAIL req_drain: %0d pending, expected 0", exp_req.size()); end
    checks++; if (exp_instr.size() != 0) begin errors++; $display("FAIL instr_drain: %0d pending, expected 0", exp_instr.size()); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
